// File: rtl/sys_defs.sv
// Shared types for the attention datapath: score format, V vector,
// running-max row index and state encoding.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package sys_defs;

   localparam int ROW_LEN   = `MAX_SEQ_LENGTH;
   localparam int ROW_IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int V_W       = 32;

   typedef logic signed [7:0]    EXPMUL_DIFF_IN_QT;
   typedef logic [V_W-1:0]       V_VECTOR_T;
   typedef logic [ROW_IDX_W-1:0] ROW_IDX_T;

   typedef enum logic {
      FIRST,
      ACCUM
   } RUNNING_MAX_STATE_T;

   localparam EXPMUL_DIFF_IN_QT Q_MIN = -8'sd128;
   localparam EXPMUL_DIFF_IN_QT Q_MAX = 8'sd127;

   typedef struct packed {
      EXPMUL_DIFF_IN_QT diff_s;
      EXPMUL_DIFF_IN_QT diff_m;
      V_VECTOR_T        v;
      logic             first;
      logic             last;
   } RM_OUT_T;

   function automatic EXPMUL_DIFF_IN_QT sat8(input logic signed [8:0] x);
      if (x < -9'sd128)
         return Q_MIN;
      else if (x > 9'sd127)
         return Q_MAX;
      else
         return x[7:0];
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer; ready toward the source is a pure register.
// Only built when RUNNING_MAX_SKID_EN is defined.
`ifdef RUNNING_MAX_SKID_EN
module skid_buffer #(
   parameter type T = logic [7:0]
) (
   input  logic clock,
   input  logic reset,
   input  logic in_vld,
   output logic in_rdy,
   input  T     in_data,
   output logic out_vld,
   input  logic out_rdy,
   output T     out_data
);

   T     main_q, main_d;
   T     skid_q, skid_d;
   logic main_vld_q, main_vld_d;
   logic skid_vld_q, skid_vld_d;
   logic rdy_q;
   logic in_fire;

   assign in_fire  = in_vld && rdy_q;
   assign in_rdy   = rdy_q;
   assign out_vld  = main_vld_q;
   assign out_data = main_q;

   // Refill main from skid first so order is kept; park input in skid on stall
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || out_rdy) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = in_fire;
            if (in_fire)
               main_d = in_data;
         end
      end else if (in_fire) begin
         skid_d     = in_data;
         skid_vld_d = 1'b1;
      end
   end

   // Storage and registered ready (open exactly when skid will be empty)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= !skid_vld_d;
      end
   end

endmodule
`endif

// File: rtl/running_max.sv
// Running row maximum for softmax: emits s-m_new and m_old-m_new per score.
// RUNNING_MAX_SKID_EN selects a registered-ready skid output stage.
module running_max
   import sys_defs::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              vld_in,
   output logic              rdy_out,
   input  logic signed [7:0] s_in,
   input  logic [V_W-1:0]    v_in,
   input  logic              rdy_in,
   output logic              vld_out,
   output logic signed [7:0] diff_s_out,
   output logic signed [7:0] diff_m_out,
   output logic [V_W-1:0]    v_out,
   output logic              first_out,
   output logic              last_out
);

   RUNNING_MAX_STATE_T state_q, state_d;
   ROW_IDX_T           idx_q, idx_d;
   EXPMUL_DIFF_IN_QT   max_q, max_d;
   EXPMUL_DIFF_IN_QT   m_old, m_new;
   logic signed [8:0]  ds, dm;
   logic               is_first, is_last;
   logic               accept;
   RM_OUT_T            bundle;
   RM_OUT_T            out_b;

   assign accept = vld_in && rdy_out;

   // Max/diff datapath and row state machine next-state
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      max_d    = max_q;
      is_first = (state_q == FIRST);
      is_last  = (idx_q == ROW_IDX_T'(ROW_LEN - 1));
      m_old    = is_first ? Q_MIN : max_q;
      m_new    = (s_in > m_old) ? s_in : m_old;
      ds       = {s_in[7], s_in} - {m_new[7], m_new};
      dm       = {m_old[7], m_old} - {m_new[7], m_new};
      bundle.diff_s = sat8(ds);
      bundle.diff_m = is_first ? Q_MIN : sat8(dm);
      bundle.v      = v_in;
      bundle.first  = is_first;
      bundle.last   = is_last;
      if (accept) begin
         max_d = m_new;
         if (is_last) begin
            state_d = FIRST;
            idx_d   = '0;
         end else begin
            state_d = ACCUM;
            idx_d   = idx_q + 1'b1;
         end
      end
   end

   // Row state, index and running max registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= FIRST;
         idx_q   <= '0;
         max_q   <= Q_MIN;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
      end
   end

`ifdef RUNNING_MAX_SKID_EN
   skid_buffer #(
      .T (RM_OUT_T)
   ) u_skid (
      .clock    (clock),
      .reset    (reset),
      .in_vld   (vld_in),
      .in_rdy   (rdy_out),
      .in_data  (bundle),
      .out_vld  (vld_out),
      .out_rdy  (rdy_in),
      .out_data (out_b)
   );
`else
   RM_OUT_T out_q;
   logic    vld_q;

   assign rdy_out = reset && (!vld_q || rdy_in);
   assign vld_out = vld_q;
   assign out_b   = out_q;

   // Single output register, refilled whenever empty or draining
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q <= 1'b0;
         out_q <= '0;
      end else if (rdy_out) begin
         vld_q <= vld_in;
         if (accept)
            out_q <= bundle;
      end
   end
`endif

   assign diff_s_out = out_b.diff_s;
   assign diff_m_out = out_b.diff_m;
   assign v_out      = out_b.v;
   assign first_out  = out_b.first;
   assign last_out   = out_b.last;

endmodule

// File: tb/tb_running_max.sv
// Directed bench for running_max: row max, saturation, stall, wrap,
// mid-row reset and streaming.
module tb_running_max;
   import sys_defs::*;

   logic              clock;
   logic              reset;
   logic              vld_in;
   logic              rdy_out;
   logic signed [7:0] s_in;
   logic [V_W-1:0]    v_in;
   logic              rdy_in;
   logic              vld_out;
   logic signed [7:0] diff_s_out;
   logic signed [7:0] diff_m_out;
   logic [V_W-1:0]    v_out;
   logic              first_out;
   logic              last_out;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   typedef struct {
      logic signed [7:0] ds;
      logic signed [7:0] dm;
      logic [V_W-1:0]    v;
      logic              f;
      logic              l;
      int                cyc;
   } rec_t;

   rec_t q[$];

   running_max dut (
      .clock      (clock),
      .reset      (reset),
      .vld_in     (vld_in),
      .rdy_out    (rdy_out),
      .s_in       (s_in),
      .v_in       (v_in),
      .rdy_in     (rdy_in),
      .vld_out    (vld_out),
      .diff_s_out (diff_s_out),
      .diff_m_out (diff_m_out),
      .v_out      (v_out),
      .first_out  (first_out),
      .last_out   (last_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (reset && vld_out && rdy_in) begin
         rec_t r;
         r.ds  = diff_s_out;
         r.dm  = diff_m_out;
         r.v   = v_out;
         r.f   = first_out;
         r.l   = last_out;
         r.cyc = cyc;
         q.push_back(r);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clock); #1;
      reset  = 1'b0;
      vld_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      q.delete();
   endtask

   task automatic send(input logic signed [7:0] s, input logic [V_W-1:0] v);
      int n = 0;
      vld_in = 1'b1;
      s_in   = s;
      v_in   = v;
      @(negedge clock);
      while (!rdy_out && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!rdy_out) begin
         n_total++;
         $display("FAIL send_timeout: rdy_out=%b required 1", rdy_out);
      end
      @(posedge clock); #1;
      vld_in = 1'b0;
   endtask

   task automatic wait_q(input int n);
      int k = 0;
      while (q.size() < n && k < 100) begin
         k++;
         @(negedge clock);
      end
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic get(input int i, output rec_t r);
      r = '{default: '0};
      if (i < q.size()) r = q[i];
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      vld_in = 1'b1;
      s_in   = 8'sd33;
      v_in   = 32'hDEAD_BEEF;
      repeat (3) @(negedge clock);
      n_total++;
      if (vld_out !== 1'b0) $display("FAIL rst_vld: got %b required 0", vld_out);
      else n_pass++;
      n_total++;
      if (rdy_out !== 1'b0) $display("FAIL rst_rdy: got %b required 0", rdy_out);
      else n_pass++;
      n_total++;
      if (diff_s_out !== 8'sd0) $display("FAIL rst_ds: got %0d required 0", diff_s_out);
      else n_pass++;
      n_total++;
      if (diff_m_out !== 8'sd0) $display("FAIL rst_dm: got %0d required 0", diff_m_out);
      else n_pass++;
      n_total++;
      if (v_out !== 32'h0) $display("FAIL rst_v: got %h required 0", v_out);
      else n_pass++;
      n_total++;
      if (first_out !== 1'b0) $display("FAIL rst_first: got %b required 0", first_out);
      else n_pass++;
      n_total++;
      if (last_out !== 1'b0) $display("FAIL rst_last: got %b required 0", last_out);
      else n_pass++;
      vld_in = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_row();
      logic signed [7:0] sc[3] = '{8'sd10, 8'sd5, 8'sd20};
      logic signed [7:0] eds[3] = '{8'sd0, -8'sd5, 8'sd0};
      logic signed [7:0] edm[3] = '{-8'sd128, 8'sd0, -8'sd10};
      logic              ef[3] = '{1'b1, 1'b0, 1'b0};
      rec_t r;
      do_reset();
      rdy_in = 1'b1;
      for (int i = 0; i < 3; i++) send(sc[i], 32'h100 + i);
      wait_q(3);
      for (int i = 0; i < 3; i++) begin
         get(i, r);
         n_total++;
         if (r.ds !== eds[i] || r.dm !== edm[i] || r.f !== ef[i] || r.l !== 1'b0)
            $display("FAIL row[%0d]: got ds=%0d dm=%0d f=%b l=%b required ds=%0d dm=%0d f=%b l=0",
                     i, r.ds, r.dm, r.f, r.l, eds[i], edm[i], ef[i]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      rec_t r;
      do_reset();
      rdy_in = 1'b1;
      send(8'sd127, 32'h200);
      send(-8'sd128, 32'h201);
      wait_q(2);
      get(0, r);
      n_total++;
      if (r.ds !== 8'sd0 || r.dm !== -8'sd128 || r.f !== 1'b1)
         $display("FAIL sat0: got ds=%0d dm=%0d f=%b required ds=0 dm=-128 f=1", r.ds, r.dm, r.f);
      else n_pass++;
      get(1, r);
      n_total++;
      if (r.ds !== -8'sd128 || r.dm !== 8'sd0 || r.f !== 1'b0)
         $display("FAIL sat1: got ds=%0d dm=%0d f=%b required ds=-128 dm=0 f=0", r.ds, r.dm, r.f);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      rec_t r;
      do_reset();
      rdy_in = 1'b0;
      send(8'sd7, 32'h300);
      fork
         begin
            send(8'sd7, 32'h301);
            send(8'sd7, 32'h302);
         end
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clock);
               n_total++;
               if (vld_out !== 1'b1 || diff_s_out !== 8'sd0 || diff_m_out !== -8'sd128 ||
                   first_out !== 1'b1 || v_out !== 32'h300)
                  $display("FAIL bp_hold[%0d]: got vld=%b ds=%0d dm=%0d f=%b v=%h required 1 0 -128 1 300",
                           i, vld_out, diff_s_out, diff_m_out, first_out, v_out);
               else n_pass++;
            end
            @(posedge clock); #1;
            rdy_in = 1'b1;
         end
      join
      wait_q(3);
      repeat (4) @(posedge clock);
      #1;
      n_total++;
      if (q.size() !== 3) $display("FAIL bp_count: got %0d required 3", q.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         get(i, r);
         n_total++;
         if (r.ds !== 8'sd0 || r.dm !== ((i == 0) ? -8'sd128 : 8'sd0) ||
             r.f !== (i == 0) || r.v !== 32'h300 + i)
            $display("FAIL bp_out[%0d]: got ds=%0d dm=%0d f=%b v=%h", i, r.ds, r.dm, r.f, r.v);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      rec_t              r;
      logic              ef, el;
      logic signed [7:0] edm;
      do_reset();
      rdy_in = 1'b1;
      for (int i = 0; i < ROW_LEN; i++) send(8'sd3, 32'h400 + i);
      send(8'sd1, 32'h4FF);
      wait_q(ROW_LEN + 1);
      for (int i = 0; i <= ROW_LEN; i++) begin
         get(i, r);
         ef  = (i == 0) || (i == ROW_LEN);
         el  = (i == ROW_LEN - 1);
         edm = ef ? -8'sd128 : 8'sd0;
         n_total++;
         if (r.ds !== 8'sd0 || r.dm !== edm || r.f !== ef || r.l !== el)
            $display("FAIL wrap[%0d]: got ds=%0d dm=%0d f=%b l=%b required ds=0 dm=%0d f=%b l=%b",
                     i, r.ds, r.dm, r.f, r.l, edm, ef, el);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_row();
      rec_t r;
      do_reset();
      rdy_in = 1'b1;
      for (int i = 0; i < 4; i++) send(8'sd50, 32'h500 + i);
      n_total++;
      if (vld_out !== 1'b1) $display("FAIL mid_pre_vld: got %b required 1", vld_out);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (vld_out !== 1'b0) $display("FAIL mid_rst_vld: got %b required 0", vld_out);
      else n_pass++;
      @(posedge clock); #1;
      reset = 1'b1;
      q.delete();
      send(-8'sd20, 32'h5AA);
      wait_q(1);
      get(0, r);
      n_total++;
      if (r.ds !== 8'sd0 || r.dm !== -8'sd128 || r.f !== 1'b1 || r.v !== 32'h5AA)
         $display("FAIL mid_first: got ds=%0d dm=%0d f=%b v=%h required 0 -128 1 5aa",
                  r.ds, r.dm, r.f, r.v);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      rec_t              r;
      logic              ef, el;
      logic signed [7:0] edm;
      do_reset();
      rdy_in = 1'b1;
      for (int i = 0; i < 16; i++)
         send(8'(-20 + 3 * (i % ROW_LEN)), 32'hA500_0000 + i * 32'h0101);
      wait_q(16);
      n_total++;
      if (q.size() !== 16) $display("FAIL stream_count: got %0d required 16", q.size());
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         get(i, r);
         ef  = (i % ROW_LEN) == 0;
         el  = (i % ROW_LEN) == ROW_LEN - 1;
         edm = ef ? -8'sd128 : -8'sd3;
         n_total++;
         if (r.v !== 32'hA500_0000 + i * 32'h0101 || r.ds !== 8'sd0 || r.dm !== edm ||
             r.f !== ef || r.l !== el)
            $display("FAIL stream[%0d]: got v=%h ds=%0d dm=%0d f=%b l=%b required dm=%0d f=%b l=%b",
                     i, r.v, r.ds, r.dm, r.f, r.l, edm, ef, el);
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (r.cyc !== q[0].cyc + i)
               $display("FAIL stream_cyc[%0d]: got %0d required %0d", i, r.cyc, q[0].cyc + i);
            else n_pass++;
         end
      end
   endtask

   initial begin
      reset  = 1'b0;
      vld_in = 1'b0;
      s_in   = '0;
      v_in   = '0;
      rdy_in = 1'b1;
      test_reset();
      test_row();
      test_saturation();
      test_backpressure();
      test_wrap();
      test_reset_mid_row();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/running_max.md
RUNNING_MAX -- requirements
Module: running_max

Interface
REQ-001 Parameter: none; row length is `MAX_SEQ_LENGTH, score type is EXPMUL_DIFF_IN_QT (8-bit signed), value vector type is V_VECTOR_T, all from sys_defs.
REQ-002 clock  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 vld_in  input  1  upstream (dot_product) score valid.
REQ-005 rdy_out  output  1  this block can accept a score this cycle.
REQ-006 s_in  input  EXPMUL_DIFF_IN_QT  score S = Q·K>>3 from dot_product.
REQ-007 v_in  input  V_VECTOR_T  V vector paired with s_in.
REQ-008 rdy_in  input  1  downstream (expmul) ready.
REQ-009 vld_out  output  1  output bundle valid.
REQ-010 diff_s_out  output  EXPMUL_DIFF_IN_QT  s - m_new, saturated.
REQ-011 diff_m_out  output  EXPMUL_DIFF_IN_QT  m_old - m_new, saturated.
REQ-012 v_out  output  V_VECTOR_T  v_in passed through, aligned with diffs.
REQ-013 first_out / last_out  output  1 each  marks first / last element of a row.

Function
REQ-014 Transfer in occurs on a rising edge with vld_in && rdy_out; transfer out on vld_out && rdy_in.
REQ-015 Latency exactly 1 cycle: a score accepted on edge N appears with vld_out=1 after edge N, when the output stage is empty or draining.
REQ-016 State machine: FIRST (next score starts a row) and ACCUM; reset enters FIRST.
REQ-017 FIRST + accept: m_old := -128, first_out=1, go to ACCUM (or stay in FIRST if `MAX_SEQ_LENGTH==1).
REQ-018 ACCUM + accept: m_old := running max register; row index increments.
REQ-019 m_new = max(m_old, s_in), signed compare; running max register := m_new on accept.
REQ-020 diff_s_out = sat8(s_in - m_new), with a 9-bit signed intermediate and a floor of -128; result is always <= 0.
REQ-021 diff_m_out = sat8(m_old - m_new), floor -128; forced to -128 when first_out=1.
REQ-022 Row index counter counts 0..`MAX_SEQ_LENGTH-1; the accept at index `MAX_SEQ_LENGTH-1 sets last_out=1, clears the index, and returns to FIRST (wrap-around).
REQ-023 Output bundle holds stable while vld_out && !rdy_in; no loss and no duplication.
REQ-024 Simultaneous accept and drain in one cycle sustains one score per cycle.
REQ-025 No accept occurs while the state machine waits; gaps in vld_in do not alter the max or the index.

Reset
REQ-026 While reset=0: vld_out=0, all data outputs 0, first_out=0, last_out=0, running max=-128, index=0, state=FIRST.
REQ-027 Reset mid-row discards the partial row; the first accept after release is treated as first_out=1.
REQ-028 rdy_out=0 while reset is asserted.

Configuration
REQ-029 Macro RUNNING_MAX_SKID_EN.
- Defined: a 2-entry skid buffer on the output; rdy_out is a register output with no combinational path from rdy_in; throughput is 1/cycle.
- Undefined: single output register; rdy_out = !vld_out || rdy_in (combinational).

Structure
REQ-030 The shared package (sys_defs) SHALL gain ROW_IDX_T, $clog2(`MAX_SEQ_LENGTH) bits, and a RUNNING_MAX_STATE_T enum {FIRST, ACCUM}.
REQ-031 Sub-module skid_buffer, parameterized on payload type, instantiated only under RUNNING_MAX_SKID_EN.

Verification
REQ-032 Row scores 10, 5, 20 with rdy_in=1 -> (diff_s, diff_m, first) = (0, -128, 1), (-5, 0, 0), (0, -10, 0).
REQ-033 Saturation: scores 127 then -128 -> second output diff_s=-128, diff_m=0.
REQ-034 Backpressure: rdy_in=0 for 3 cycles with vld_in held at score 7 -> bundle stable; exactly one output appears per accepted score after rdy_in=1; identical outputs under both macro settings.
REQ-035 Wrap-around: `MAX_SEQ_LENGTH scores of value 3, then score 1 -> last_out=1 only on element `MAX_SEQ_LENGTH-1; the next output has first_out=1, diff_m=-128, diff_s=0.
REQ-036 Reset mid-row: reset low for 1 cycle after 4 scores of 50 -> vld_out falls immediately; next score -20 gives first_out=1, diff_s=0.
REQ-037 Streaming with vld_in=rdy_in=1 continuously for 16 scores -> 16 outputs on 16 consecutive cycles; v_out matches v_in order exactly.
